instr_prefetch: RTL and testbench
=================================

// Module: instr_prefetch
// PURPOSE
//  Instruction prefetch queue between instruction memory (im) and the instruction register (ir).
//  Generates fetch addresses and issues at most one outstanding im request at a time.
//  Buffers returned words, each tagged with its address, in a small FIFO.
//  Presents the queue head to the controller with a valid/ready handshake.
//  A taken branch flushes the queue and restarts fetch at the branch target.
// PARAMETERS
//  DEPTH   4   queue entries (power of 2, >=2)
//  AW      16  instruction address width (word addressed, matches pc)
//  DW      32  instruction width
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_f        in   1   asynchronous active-low reset
//  flush        in   1   redirect: discard queue and in-flight word
//  flush_addr   in   AW  restart address, sampled when flush=1
//  im_req       out  1   one-cycle request strobe to im
//  im_addr      out  AW  fetch address, valid while im_req=1
//  im_rdata     in   DW  returned instruction word
//  im_rvalid    in   1   im_rdata valid; arrives >=1 cycle after im_req
//  instr_valid  out  1   queue head valid
//  instr_ready  in   1   consumer takes head this cycle (ir_load)
//  instr_out    out  DW  head instruction word
//  instr_pc     out  AW  address of head instruction (feeds br)
//  q_count      out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  Reset (async, rst_f=0) forces:
//   - im_req=0, im_addr=0, instr_valid=0, instr_out=0, instr_pc=0, q_count=0.
//   - FSM in S_IDLE; fetch pointer fpc=0.
//  FSM states:
//   - S_IDLE: no request outstanding. If (q_count + 0) < DEPTH and flush=0: im_req=1, im_addr=fpc, fpc<=fpc+1, go S_WAIT.
//   - S_WAIT: on im_rvalid: push {fpc_tag, im_rdata}, go S_IDLE.
//   - S_DROP: await im_rvalid, discard the data, go S_IDLE.
//  Credit rule: issue only when entries + outstanding < DEPTH, so a push never finds the queue full.
//   - im_rvalid with the FIFO full is impossible by construction; the bench asserts it never occurs.
//  Pop occurs when instr_valid & instr_ready.
//   - Push and pop in the same cycle leave q_count unchanged.
//  Latency:
//   - Back-to-back requests issue at a rate of one per (im latency + 1) cycles.
//   - Without bypass, a response reaches instr_valid 1 cycle after im_rvalid.
//  fpc arithmetic: AW-bit, increments by 1, wraps from {AW{1}} to 0 without error.
//  Flush (takes priority over everything):
//   - q_count<=0, instr_valid<=0, fpc<=flush_addr. Any pop in the same cycle is ignored.
//   - From S_WAIT without im_rvalid: go S_DROP.
//   - From S_WAIT with im_rvalid in the same cycle: discard that word, go S_IDLE.
//   - From S_DROP: stay in S_DROP; fpc takes the newest flush_addr.
//   - In the flush cycle itself no im_req is issued; fetch resumes on the next cycle.
//  instr_out/instr_pc hold their last values when instr_valid=0.
//  Reset mid-request: the state is lost and any late im_rvalid after reset is ignored. im must also be reset by rst_f.
// CONFIGURATION
//  IFQ_BYPASS_EN defined:
//   - With the queue empty, a non-stale im_rvalid drives instr_valid=1, instr_out=im_rdata, and instr_pc=tag combinationally in the same cycle.
//   - If instr_ready=1 that cycle, the word is consumed and never written to the FIFO.
//   - Otherwise the word is written to the FIFO.
//  IFQ_BYPASS_EN undefined: all words pass through the FIFO, giving a fixed 1-cycle extra latency.
// STRUCTURE
//  Shared package sisc_pkg:
//   - SISC_AW=16, SISC_DW=32.
//   - FSM state typedef ifq_state_t {S_IDLE, S_WAIT, S_DROP}.
//   - Fetch entry struct {addr, word}.
//  Sub-module ifq_fifo:
//   - Synchronous DEPTH x (AW+DW) circular buffer.
//   - Ports: push, pop, clear, count, head; wrap-around read/write pointers.
//  Top level: FSM, fpc, tag register, credit check, bypass mux.
// TESTING
//  1. Reset, im latency 1, instr_ready=1:
//     im_addr sequence 0,1,2,...; instr_pc follows 0,1,2 with instr_out = mem[pc].
//  2. instr_ready=0 for 20 cycles:
//     q_count saturates at 4; exactly 4 im_req issued, then none.
//     Release: words 0..3 pop in order, fetch resumes at 4.
//  3. flush=1, flush_addr=16'h0040 while in S_WAIT:
//     the late im_rvalid word is dropped; next im_addr=0x0040; first instr_pc=0x0040; q_count=0 in the cycle after flush.
//  4. flush in the same cycle as im_rvalid and a pop:
//     word discarded, pop ignored, q_count=0, next im_addr=flush_addr.
//  5. flush_addr=16'hFFFE:
//     im_addr sequence FFFE, FFFF, 0000, 0001.
//  6. With IFQ_BYPASS_EN, empty queue, im latency 1:
//     instr_valid rises in the im_rvalid cycle, and q_count stays 0 with instr_ready=1.
//     Without the macro, instr_valid rises one cycle later.

Source files
------------

// File: rtl/sisc_pkg.sv
// sisc_pkg: shared widths, prefetch FSM states and fetch entry type.
package sisc_pkg;
    localparam int SISC_AW = 16;
    localparam int SISC_DW = 32;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} ifq_state_t;
    typedef struct packed {
        logic [SISC_AW-1:0] addr;
        logic [SISC_DW-1:0] word;
    } fetch_entry_t;
endpackage

// File: rtl/instr_prefetch_if.sv
// instr_prefetch_if: im request/response bus plus instruction handshake to the consumer.
interface instr_prefetch_if
    import sisc_pkg::*;
#(parameter int AW = SISC_AW, parameter int DW = SISC_DW, parameter int CW = 3);
    logic          im_req;
    logic [AW-1:0] im_addr;
    logic [DW-1:0] im_rdata;
    logic          im_rvalid;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic [CW-1:0] q_count;
    modport master (
        output im_req, im_addr, instr_valid, instr_out, instr_pc, q_count,
        input  im_rdata, im_rvalid, instr_ready
    );
    modport slave (
        input  im_req, im_addr, instr_valid, instr_out, instr_pc, q_count,
        output im_rdata, im_rvalid, instr_ready
    );
endinterface

// File: rtl/ifq_fifo.sv
// ifq_fifo: DEPTH-entry circular buffer of tagged fetch words with clear.
module ifq_fifo
    import sisc_pkg::*;
#(parameter int DEPTH = 4, parameter int W = SISC_AW + SISC_DW) (
    input  logic                   clk,
    input  logic                   rst_f,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [W-1:0]           din,
    output logic [$clog2(DEPTH):0] count,
    output logic [W-1:0]           head
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [PW:0]   r_cnt;
    always_ff @(posedge clk)
        if (push) r_mem[r_wp] <= din;
    always_ff @(posedge clk or negedge rst_f)
        if (!rst_f) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (clear) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            r_wp  <= r_wp + PW'(push);
            r_rp  <= r_rp + PW'(pop);
            r_cnt <= r_cnt + (PW+1)'(push) - (PW+1)'(pop);
        end
    assign count = r_cnt;
    assign head  = r_mem[r_rp];
endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: single-outstanding im fetcher feeding a tagged FIFO with branch flush.
// Define IFQ_BYPASS_EN to forward a response straight to the consumer when the queue is empty.
module instr_prefetch
    import sisc_pkg::*;
#(parameter int DEPTH = 4, parameter int AW = SISC_AW, parameter int DW = SISC_DW) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic            flush,
    input  logic [AW-1:0]   flush_addr,
    instr_prefetch_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    ifq_state_t       r_state, w_next;
    logic             r_en, w_req, w_rv, w_byp, w_push, w_pop;
    logic [AW-1:0]    r_fpc, r_tag, r_hold_pc;
    logic [DW-1:0]    r_hold_word;
    logic [CW-1:0]    w_count;
    logic [AW+DW-1:0] w_head;

    assign w_rv = (r_state == S_WAIT) && bus.im_rvalid && !flush;
`ifdef IFQ_BYPASS_EN
    assign w_byp = w_rv && (w_count == '0);
`else
    assign w_byp = 1'b0;
`endif
    assign w_push = w_rv && !(w_byp && bus.instr_ready);
    assign w_pop  = (w_count != '0) && bus.instr_ready && !flush;

    ifq_fifo #(.DEPTH(DEPTH), .W(AW + DW)) u_fifo (
        .clk(clk), .rst_f(rst_f), .push(w_push), .pop(w_pop), .clear(flush),
        .din({r_tag, bus.im_rdata}), .count(w_count), .head(w_head)
    );

    // Issuing only from S_IDLE keeps entries + outstanding <= DEPTH, so a push never overflows.
    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req  = r_en && !flush && (w_count < CW'(DEPTH));
                w_next = w_req ? S_WAIT : S_IDLE;
            end
            S_WAIT:  w_next = bus.im_rvalid ? S_IDLE : (flush ? S_DROP : S_WAIT);
            S_DROP:  w_next = bus.im_rvalid ? S_IDLE : S_DROP;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f)
        if (!rst_f) r_state <= S_IDLE;
        else        r_state <= w_next;

    // r_en holds off the first request until one clock after reset release.
    always_ff @(posedge clk or negedge rst_f)
        if (!rst_f) begin
            r_en        <= 1'b0;
            r_fpc       <= '0;
            r_tag       <= '0;
            r_hold_pc   <= '0;
            r_hold_word <= '0;
        end else begin
            r_en <= 1'b1;
            if (flush)      r_fpc <= flush_addr;
            else if (w_req) r_fpc <= r_fpc + 1'b1;
            if (w_req) r_tag <= r_fpc;
            if (bus.instr_valid) begin
                r_hold_pc   <= bus.instr_pc;
                r_hold_word <= bus.instr_out;
            end
        end

    assign bus.im_req      = w_req;
    assign bus.im_addr     = r_fpc;
    assign bus.q_count     = w_count;
    assign bus.instr_valid = (w_count != '0) || w_byp;
    assign bus.instr_pc    = !bus.instr_valid ? r_hold_pc :
                             (w_byp ? r_tag : w_head[AW+DW-1:DW]);
    assign bus.instr_out   = !bus.instr_valid ? r_hold_word :
                             (w_byp ? bus.im_rdata : w_head[DW-1:0]);
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: randomized scoreboard bench with an im responder and occupancy model.
module tb_instr_prefetch;
    import sisc_pkg::*;
    localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0, rst_f = 1'b0, flush = 1'b0;
    logic [15:0] flush_addr = '0;

    instr_prefetch_if #(.AW(16), .DW(32), .CW(3)) bus ();
    instr_prefetch #(.DEPTH(DEPTH), .AW(16), .DW(32)) dut (
        .clk(clk), .rst_f(rst_f), .flush(flush), .flush_addr(flush_addr), .bus(bus)
    );

    always #5 clk = ~clk;

    int           checks = 0, failures = 0;
    fetch_entry_t exp_q[$];
    logic [15:0]  m_fpc = '0;
    bit           pend = 0, pstale = 0, rv_stale = 0, got_rv = 0, run = 0;
    int           pcnt = 0, lat = 1, reqs = 0;
    logic [15:0]  paddr = '0;
    logic [15:0]  req_log [8];
    int           n_ret = 0, n_con = 0;
    logic [15:0]  last_pc = '0;
    logic [31:0]  last_out = '0;

    function automatic logic [31:0] mem(input logic [15:0] a);
        return {a * 16'd3 + 16'h1234, ~a};
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs just after the edge, model the im, observe at the falling edge.
    task automatic step(input logic f, input logic [15:0] fa, input logic rdy, input bit frv);
        @(posedge clk);
        #1;
        bus.im_rvalid = 1'b0;
        got_rv = 0;
        if (pend) begin
            pcnt--;
            if (pcnt == 0) begin
                bus.im_rvalid = 1'b1;
                bus.im_rdata  = mem(paddr);
                rv_stale = pstale;
                pend = 0;
                got_rv = 1;
            end
        end
        flush           = f | (frv & got_rv);
        flush_addr      = fa;
        bus.instr_ready = rdy | (frv & got_rv);
        @(negedge clk);
        if (bus.im_req) begin
            chk("im_req_legal", 48'({flush, pend}), 48'(0));
            chk("im_addr", 48'(bus.im_addr), 48'(m_fpc));
            exp_q.push_back('{addr: m_fpc, word: mem(m_fpc)});
            m_fpc++;
            pend = 1;
            pstale = 0;
            paddr = bus.im_addr;
            pcnt = lat;
            if (reqs < 8) req_log[reqs] = bus.im_addr;
            reqs++;
        end
        if (flush) begin
            m_fpc = flush_addr;
            exp_q.delete();
            pstale = 1;
        end
    endtask

    // Monitor: occupancy/valid model plus in-order scoreboard of consumed words.
    initial begin
        bit live;
        int occ;
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (run) begin
                live = bus.im_rvalid && !rv_stale && !flush;
                occ  = n_ret - n_con;
                chk("q_count", 48'(bus.q_count), 48'(occ));
                chk("instr_valid", 48'(bus.instr_valid), 48'((occ != 0) || (BYP && live)));
                if (bus.im_rvalid) chk("rvalid_not_full", 48'(bus.q_count == 3'(DEPTH)), 48'(0));
                if (!bus.instr_valid) begin
                    chk("hold_pc", 48'(bus.instr_pc), 48'(last_pc));
                    chk("hold_out", 48'(bus.instr_out), 48'(last_out));
                end else begin
                    last_pc  = bus.instr_pc;
                    last_out = bus.instr_out;
                end
                if (flush) begin
                    n_ret = 0;
                    n_con = 0;
                end else begin
                    if (live) n_ret++;
                    if (bus.instr_valid && bus.instr_ready) begin
                        if (exp_q.size() == 0) chk("sb_nonempty", 48'(exp_q.size()), 48'(1));
                        else begin
                            e = exp_q.pop_front();
                            chk("instr_pc", 48'(bus.instr_pc), 48'(e.addr));
                            chk("instr_out", 48'(bus.instr_out), 48'(e.word));
                        end
                        n_con++;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit done, hit;
        bus.im_rvalid = 1'b0;
        bus.im_rdata = '0;
        bus.instr_ready = 1'b0;
        #12;
        chk("rst_im_req", 48'(bus.im_req), 48'(0));
        chk("rst_im_addr", 48'(bus.im_addr), 48'(0));
        chk("rst_valid", 48'(bus.instr_valid), 48'(0));
        chk("rst_out", 48'(bus.instr_out), 48'(0));
        chk("rst_pc", 48'(bus.instr_pc), 48'(0));
        chk("rst_qcount", 48'(bus.q_count), 48'(0));
        @(negedge clk);
        rst_f = 1'b1;
        run = 1;
        // Streaming at im latency 1: one request every two cycles from address 0.
        lat = 1;
        repeat (30) step(0, 16'h0, 1, 0);
        chk("p1_req_count", 48'(reqs), 48'(15));
        // Backpressure: queue fills to DEPTH with exactly DEPTH requests.
        step(1, 16'h0, 0, 0);
        reqs = 0;
        repeat (20) step(0, 16'h0, 0, 0);
        chk("p2_reqs", 48'(reqs), 48'(4));
        chk("p2_qcount", 48'(bus.q_count), 48'(4));
        reqs = 0;
        repeat (20) step(0, 16'h0, 1, 0);
        chk("p2_resume_addr", 48'(req_log[0]), 48'(4));
        // Flush while a request is outstanding.
        lat = 3;
        reqs = 0;
        for (int i = 0; i < 10 && reqs == 0; i++) step(0, 16'h0, 1, 0);
        chk("p3_req_seen", 48'(reqs), 48'(1));
        step(1, 16'h0040, 1, 0);
        lat = 1;
        reqs = 0;
        step(0, 16'h0, 1, 0);
        chk("p3_qcount", 48'(bus.q_count), 48'(0));
        repeat (20) step(0, 16'h0, 1, 0);
        chk("p3_first_addr", 48'(req_log[0]), 48'(16'h0040));
        // Flush coinciding with a response and a pop.
        for (int i = 0; i < 20 && bus.q_count < 2; i++) step(0, 16'h0, 0, 0);
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            step(0, 16'h0123, 0, 1);
            done = got_rv;
            if (got_rv) chk("p4_valid_at_flush", 48'(bus.instr_valid), 48'(1));
        end
        chk("p4_flush_hit", 48'(done), 48'(1));
        reqs = 0;
        step(0, 16'h0, 1, 0);
        chk("p4_qcount", 48'(bus.q_count), 48'(0));
        repeat (10) step(0, 16'h0, 1, 0);
        chk("p4_addr", 48'(req_log[0]), 48'(16'h0123));
        // Fetch address wrap.
        step(1, 16'hFFFE, 1, 0);
        reqs = 0;
        repeat (12) step(0, 16'h0, 1, 0);
        chk("p5_addr0", 48'(req_log[0]), 48'(16'hFFFE));
        chk("p5_addr1", 48'(req_log[1]), 48'(16'hFFFF));
        chk("p5_addr2", 48'(req_log[2]), 48'(16'h0000));
        chk("p5_addr3", 48'(req_log[3]), 48'(16'h0001));
        // Empty-queue response latency.
        step(1, 16'h0200, 1, 0);
        hit = 0;
        for (int i = 0; i < 12 && !hit; i++) begin
            step(0, 16'h0, 1, 0);
            hit = got_rv && !rv_stale;
        end
        chk("p6_hit", 48'(hit), 48'(1));
        chk("p6_valid_rv_cycle", 48'(bus.instr_valid), 48'(BYP));
        chk("p6_qcount_rv_cycle", 48'(bus.q_count), 48'(0));
        step(0, 16'h0, 1, 0);
        chk("p6_valid_next", 48'(bus.instr_valid), 48'(!BYP));
        chk("p6_qcount_next", 48'(bus.q_count), 48'(BYP ? 0 : 1));
        // Randomized latency, backpressure and redirects.
        repeat (3000) begin
            lat = $urandom_range(1, 3);
            step($urandom_range(0, 49) == 0, 16'($urandom), $urandom_range(0, 3) != 0, 0);
        end
        repeat (20) step(0, 16'h0, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
